// File: rtl/btn_debounce_array.sv
// Multi-channel counter-based button debouncer: per channel a synchroniser, a
// press/release confirm window, a long-press detector and single-cycle event pulses.
module btn_debounce_array #(
    parameter int N_CH        = 4,
    parameter int STABLE_CYC  = 16,
    parameter int LONG_CYC    = 1000,
    parameter int ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    localparam int CW = $clog2(LONG_CYC + 1);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] PRESS_CHK   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] RELEASE_CHK = 2'd3;

    // Raw level of a released button; XOR with it yields 1 = pressed.
    localparam logic          REL_LVL  = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYC);
    localparam logic [CW-1:0] LONG_C   = CW'(LONG_CYC);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   p;
            logic [1:0]             state_reg, state_next;
            logic [CW-1:0]          cnt_reg, cnt_next;
            logic [CW-1:0]          hold_reg, hold_next, hold_inc;
            logic                   hold_run;
            logic                   level_reg, level_next;
            logic                   press_reg, press_next;
            logic                   release_reg, release_next;
            logic                   long_reg, long_next;

            assign p        = sync_reg[SYNC_STAGES-1] ^ REL_LVL;
            assign hold_inc = hold_reg + 1'b1;

            always_comb begin
                state_next   = state_reg;
                cnt_next     = cnt_reg;
                hold_next    = hold_reg;
                hold_run     = 1'b0;
                press_next   = 1'b0;
                release_next = 1'b0;
                long_next    = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (p) begin
                            state_next = PRESS_CHK;
                            cnt_next   = CW'(1);
                        end
                    end
                    PRESS_CHK: begin
                        if (!p) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == STABLE_C) begin
                            state_next = PRESSED;
                            cnt_next   = '0;
                            hold_next  = '0;
                            press_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    PRESSED: begin
                        hold_run = 1'b1;
                        if (!p) begin
                            state_next = RELEASE_CHK;
                            cnt_next   = CW'(1);
                        end
                    end
                    RELEASE_CHK: begin
                        if (p) begin
                            state_next = PRESSED;
                            cnt_next   = '0;
                            hold_run   = 1'b1;
                        end else if (cnt_reg == STABLE_C) begin
                            state_next   = IDLE;
                            cnt_next     = '0;
                            hold_next    = '0;
                            release_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                            hold_run = 1'b1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        hold_next  = '0;
                    end
                endcase
                // Hold keeps counting through release bounces and saturates so long fires once.
                if (hold_run && (hold_reg != LONG_C)) begin
                    hold_next = hold_inc;
                    long_next = (hold_inc == LONG_C);
                end
                level_next = (state_next == PRESSED) || (state_next == RELEASE_CHK);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg    <= {SYNC_STAGES{REL_LVL}};
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    hold_reg    <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    long_reg    <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], btn[gi]};
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    hold_reg    <= hold_next;
                    level_reg   <= level_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                    long_reg    <= long_next;
                end
            end

            assign btn_level[gi]     = level_reg;
            assign press_pulse[gi]   = press_reg;
            assign release_pulse[gi] = release_reg;
            assign long_pulse[gi]    = long_reg;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_array.sv
// Bench for btn_debounce_array: directed latency/bounce/long/reset scenarios plus
// randomized traffic checked against a run-length reference model.
module tb_btn_debounce_array;
    localparam int N  = 2;
    localparam int ST = 4;
    localparam int LG = 20;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn, btn_b;
    logic [N-1:0] lvl_a, pp_a, rp_a, lp_a;
    logic [N-1:0] lvl_b, pp_b, rp_b, lp_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btn_debounce_array #(.N_CH(N), .STABLE_CYC(ST), .LONG_CYC(LG), .ACTIVE_LOW(1), .SYNC_STAGES(SS)) dut_a (
        .clk(clk), .rst(rst), .btn(btn),
        .btn_level(lvl_a), .press_pulse(pp_a), .release_pulse(rp_a), .long_pulse(lp_a)
    );

    btn_debounce_array #(.N_CH(N), .STABLE_CYC(ST), .LONG_CYC(LG), .ACTIVE_LOW(0), .SYNC_STAGES(SS)) dut_b (
        .clk(clk), .rst(rst), .btn(btn_b),
        .btn_level(lvl_b), .press_pulse(pp_b), .release_pulse(rp_b), .long_pulse(lp_b)
    );

    // Reference model: an event fires once the pressed/released input has disagreed with
    // the debounced level for ST+1 consecutive samples; long fires LG cycles after press.
    bit           m_pipe [2][N][SS];
    bit           m_lvl  [2][N];
    int           m_run  [2][N];
    int           m_hold [2][N];
    logic [N-1:0] e_lvl [2];
    logic [N-1:0] e_pp  [2];
    logic [N-1:0] e_rp  [2];
    logic [N-1:0] e_lp  [2];

    always @(posedge clk) begin
        for (int ins = 0; ins < 2; ins++) begin
            for (int ch = 0; ch < N; ch++) begin : model_ch
                bit nrm;
                bit p;
                nrm = (ins == 0) ? ~btn[ch] : btn_b[ch];
                p   = m_pipe[ins][ch][SS-1];
                for (int j = SS - 1; j > 0; j--) m_pipe[ins][ch][j] = m_pipe[ins][ch][j-1];
                m_pipe[ins][ch][0] = nrm;
                e_pp[ins][ch] = 1'b0;
                e_rp[ins][ch] = 1'b0;
                e_lp[ins][ch] = 1'b0;
                if (rst) begin
                    for (int j = 0; j < SS; j++) m_pipe[ins][ch][j] = 1'b0;
                    m_lvl[ins][ch]  = 1'b0;
                    m_run[ins][ch]  = 0;
                    m_hold[ins][ch] = 0;
                end else begin
                    m_run[ins][ch] = (p != m_lvl[ins][ch]) ? m_run[ins][ch] + 1 : 0;
                    if (m_run[ins][ch] == ST + 1) begin
                        m_run[ins][ch]  = 0;
                        m_hold[ins][ch] = 0;
                        if (!m_lvl[ins][ch]) e_pp[ins][ch] = 1'b1;
                        else                 e_rp[ins][ch] = 1'b1;
                        m_lvl[ins][ch] = ~m_lvl[ins][ch];
                    end else if (m_lvl[ins][ch]) begin
                        m_hold[ins][ch]++;
                        if (m_hold[ins][ch] == LG) e_lp[ins][ch] = 1'b1;
                    end
                end
                e_lvl[ins][ch] = m_lvl[ins][ch];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if ({lvl_a, pp_a, rp_a, lp_a, lvl_b, pp_b, rp_b, lp_b} !== '0)
            begin bad++; $display("FAIL reset_state: got %h expected 0", {lvl_a, pp_a, rp_a, lp_a, lvl_b, pp_b, rp_b, lp_b}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_clean_press();
        int n = 0;
        bit seen = 0;
        bit other_ok = 1;
        btn[0] = 1'b0;
        while (!seen && n < 30) begin
            step(); n++;
            if (pp_a[0]) seen = 1;
            if ({lvl_a[1], pp_a[1], rp_a[1], lp_a[1]} != 4'b0) other_ok = 0;
        end
        total++;
        if (!seen || n != 7) begin bad++; $display("FAIL clean_press_latency: got %0d cycles (seen=%0d) expected 7", n, seen); end
        total++;
        if (lvl_a[0] !== 1'b1) begin bad++; $display("FAIL clean_press_level: got %b expected 1", lvl_a[0]); end
        step();
        total++;
        if (pp_a[0] !== 1'b0 || lvl_a[0] !== 1'b1)
            begin bad++; $display("FAIL clean_press_width: got pulse=%b level=%b expected pulse=0 level=1", pp_a[0], lvl_a[0]); end
        repeat (7) begin
            step();
            if ({lvl_a[1], pp_a[1], rp_a[1], lp_a[1]} != 4'b0) other_ok = 0;
        end
        total++;
        if (!other_ok) begin bad++; $display("FAIL clean_press_other_channel: got activity expected none"); end
        btn[0] = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 30) begin
            step(); n++;
            if (rp_a[0]) seen = 1;
        end
        total++;
        if (!seen || n != 7 || lvl_a[0] !== 1'b0)
            begin bad++; $display("FAIL clean_release: got %0d cycles level=%b expected 7 cycles level=0", n, lvl_a[0]); end
        $display("clean press/release done");
        repeat (5) step();
    endtask

    task automatic test_bounce();
        bit quiet = 1;
        for (int t = 0; t < 30; t++) begin
            btn[0] = (t < 20) ? ((t % 4) == 3) : 1'b1;
            step();
            if (pp_a[0] || rp_a[0] || lp_a[0] || lvl_a[0]) quiet = 0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL bounce: got event or level on channel 0 expected none"); end
        $display("bounce sequence done");
    endtask

    task automatic test_long();
        int press_t = -1, long_t = -1, rel_t = -1;
        int press_n = 0, long_n = 0, rel_n = 0;
        for (int t = 1; t <= 60; t++) begin
            btn[0] = (t <= 40 && t != 25) ? 1'b0 : 1'b1;
            step();
            if (pp_a[0]) begin press_n++; press_t = t; end
            if (lp_a[0]) begin long_n++;  long_t  = t; end
            if (rp_a[0]) begin rel_n++;   rel_t   = t; end
        end
        total++;
        if (press_n != 1 || press_t != 7) begin bad++; $display("FAIL long_press_pulse: got n=%0d t=%0d expected n=1 t=7", press_n, press_t); end
        total++;
        if (long_n != 1 || long_t != 27) begin bad++; $display("FAIL long_pulse: got n=%0d t=%0d expected n=1 t=27", long_n, long_t); end
        total++;
        if (rel_n != 1 || rel_t != 47) begin bad++; $display("FAIL long_release: got n=%0d t=%0d expected n=1 t=47", rel_n, rel_t); end
        $display("long press: press@%0d long@%0d release@%0d", press_t, long_t, rel_t);
    endtask

    task automatic test_simultaneous();
        int n = 0;
        int r0 = -1, r1 = -1;
        bit single = 1;
        btn = 2'b00;
        while (pp_a == 2'b00 && n < 30) begin step(); n++; end
        total++;
        if (pp_a !== 2'b11 || n != 7) begin bad++; $display("FAIL simul_press: got %b at %0d expected 11 at 7", pp_a, n); end
        repeat (3) step();
        for (int t = 1; t <= 20; t++) begin
            if (t == 1) btn[0] = 1'b1;
            if (t == 4) btn[1] = 1'b1;
            step();
            if (rp_a == 2'b11) single = 0;
            if (rp_a[0]) r0 = t;
            if (rp_a[1]) r1 = t;
        end
        total++;
        if (r0 != 7 || r1 != 10 || !single) begin bad++; $display("FAIL simul_release: got r0=%0d r1=%0d expected r0=7 r1=10", r0, r1); end
        $display("simultaneous press and staggered release done");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen = 0;
        bit no_rel = 1;
        btn[0] = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        total++;
        if ({lvl_a, pp_a, rp_a, lp_a} !== '0) begin bad++; $display("FAIL reset_in_press_chk: got %h expected 0", {lvl_a, pp_a, rp_a, lp_a}); end
        rst = 1'b0;
        while (!seen && n < 30) begin step(); n++; if (pp_a[0]) seen = 1; end
        total++;
        if (!seen || n != 7) begin bad++; $display("FAIL reset_repress1: got %0d cycles expected 7", n); end
        repeat (5) step();
        rst = 1'b1;
        step();
        total++;
        if ({lvl_a, pp_a, rp_a, lp_a} !== '0) begin bad++; $display("FAIL reset_in_pressed: got %h expected 0", {lvl_a, pp_a, rp_a, lp_a}); end
        rst = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 30) begin
            step(); n++;
            if (pp_a[0]) seen = 1;
            if (rp_a[0]) no_rel = 0;
        end
        total++;
        if (!seen || n != 7 || !no_rel) begin bad++; $display("FAIL reset_repress2: got %0d cycles no_rel=%0d expected 7 no_rel=1", n, no_rel); end
        btn[0] = 1'b1;
        repeat (12) step();
        $display("reset mid-operation done");
    endtask

    task automatic test_active_high();
        int n = 0;
        bit seen = 0;
        btn_b[0] = 1'b1;
        while (!seen && n < 30) begin step(); n++; if (pp_b[0]) seen = 1; end
        total++;
        if (!seen || n != 7 || lvl_b[0] !== 1'b1) begin bad++; $display("FAIL active_high_press: got %0d cycles level=%b expected 7 level=1", n, lvl_b[0]); end
        total++;
        if (lvl_a !== 2'b00) begin bad++; $display("FAIL active_high_isolation: got %b expected 00", lvl_a); end
        repeat (3) step();
        btn_b[0] = 1'b0;
        repeat (10) step();
        total++;
        if (lvl_b[0] !== 1'b0) begin bad++; $display("FAIL active_high_release: got level=%b expected 0", lvl_b[0]); end
        $display("active-high instance done");
    endtask

    task automatic test_random();
        int errs = 0;
        for (int t = 0; t < 1500; t++) begin
            int odds;
            odds = (t < 750) ? 8 : 40;
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, odds - 1) == 0) btn[ch]   = ~btn[ch];
                if ($urandom_range(0, odds - 1) == 0) btn_b[ch] = ~btn_b[ch];
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
            total++;
            if ({lvl_a, pp_a, rp_a, lp_a} !== {e_lvl[0], e_pp[0], e_rp[0], e_lp[0]} ||
                {lvl_b, pp_b, rp_b, lp_b} !== {e_lvl[1], e_pp[1], e_rp[1], e_lp[1]}) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL random_cycle %0d: got a=%h b=%h expected a=%h b=%h", t,
                             {lvl_a, pp_a, rp_a, lp_a}, {lvl_b, pp_b, rp_b, lp_b},
                             {e_lvl[0], e_pp[0], e_rp[0], e_lp[0]}, {e_lvl[1], e_pp[1], e_rp[1], e_lp[1]});
            end
        end
        rst = 1'b0;
        $display("random traffic done, mismatching cycles=%0d", errs);
    endtask

    initial begin
        rst   = 1'b1;
        btn   = 2'b11;
        btn_b = 2'b00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long();
        test_simultaneous();
        test_reset_mid();
        test_active_high();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
